// File: rtl/mnist_nn_usb_rst_seq.sv
// USB controller reset sequencer: holds usb_rst_n low for a minimum pulse, then waits out
// a recovery window before flagging completion. Runs once automatically after every power-on.
module mnist_nn_usb_rst_seq #(
  parameter int unsigned ASSERT_CYCLES  = 16,
  parameter int unsigned RECOVER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rst_req,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [15:0] ASSERT_LOAD  = 16'(ASSERT_CYCLES - 32'd1);
  localparam logic [15:0] RECOVER_LOAD = 16'(RECOVER_CYCLES - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic        usb_rst_n_r;
  logic        done_r;
  logic        done_nxt_s;
  logic        irq_en_r;
  logic        irq_en_nxt_s;
  logic        req_q_r;
  logic        wr_s;
  logic        go_s;
  logic        start_s;
  logic        done_set_s;
  logic        done_clr_s;
  logic        unused_s;

  assign wr_s       = chipselect & ~write_n;
  assign go_s       = wr_s & (address == 2'd0) & writedata[0];
  assign start_s    = (rst_req & ~req_q_r) | go_s;
  assign done_clr_s = wr_s & (address == 2'd1) & writedata[0];
  assign unused_s   = ^writedata[31:1];

  // State, counter, flag and output registers; reset lands in ASSERT so power-on pulses the chip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_ASSERT;
      cnt_r       <= ASSERT_LOAD;
      usb_rst_n_r <= 1'b0;
      done_r      <= 1'b0;
      irq_en_r    <= 1'b0;
      req_q_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      usb_rst_n_r <= (state_nxt_s != ST_ASSERT);
      done_r      <= done_nxt_s;
      irq_en_r    <= irq_en_nxt_s;
      req_q_r     <= rst_req;
    end
  end

  // Next-state and counter; a held request keeps ASSERT alive once the minimum pulse has elapsed.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_ASSERT;
          cnt_nxt_s   = ASSERT_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (cnt_r != 16'd0) begin
          cnt_nxt_s = cnt_r - 16'd1;
        end else if (!rst_req) begin
          state_nxt_s = ST_RECOVER;
          cnt_nxt_s   = RECOVER_LOAD;
        end else begin
          state_nxt_s = ST_ASSERT;
        end
      end
      ST_RECOVER: begin
        if (start_s) begin
          state_nxt_s = ST_ASSERT;
          cnt_nxt_s   = ASSERT_LOAD;
        end else if (cnt_r == 16'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 16'd1;
        end
      end
      default: begin
        state_nxt_s = ST_ASSERT;
        cnt_nxt_s   = ASSERT_LOAD;
      end
    endcase
  end

  // Outputs and register-file updates; completion beats a same-cycle clear of done.
  always_comb begin
    done_set_s   = (state_r == ST_RECOVER) && (cnt_r == 16'd0) && !start_s;
    done_nxt_s   = done_r;
    irq_en_nxt_s = irq_en_r;
    readdata     = 32'd0;
    if (done_set_s) begin
      done_nxt_s = 1'b1;
    end else if (done_clr_s) begin
      done_nxt_s = 1'b0;
    end else begin
      done_nxt_s = done_r;
    end
    if (wr_s && (address == 2'd2)) begin
      irq_en_nxt_s = writedata[0];
    end else begin
      irq_en_nxt_s = irq_en_r;
    end
    case (address)
      2'd0:    readdata = {28'd0, state_r, done_r, (state_r != ST_IDLE)};
      2'd1:    readdata = {31'd0, done_r};
      2'd2:    readdata = {31'd0, irq_en_r};
      2'd3:    readdata = {16'd0, cnt_r};
      default: readdata = 32'd0;
    endcase
  end

  assign usb_rst_n = usb_rst_n_r;
  assign busy      = (state_r != ST_IDLE);
  assign irq       = done_r & irq_en_r;

endmodule

// File: tb/tb_mnist_nn_usb_rst_seq.sv
// Scoreboard bench: expected low-pulse and recovery lengths are queued per scenario and
// checked by a monitor when usb_rst_n rises and when busy falls.
module tb_mnist_nn_usb_rst_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        rst_req = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        usb_rst_n;
  logic        busy;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_low_q[$];
  int exp_rec_q[$];

  mnist_nn_usb_rst_seq #(.ASSERT_CYCLES(4), .RECOVER_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .rst_req(rst_req), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .usb_rst_n(usb_rst_n), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts at posedge+2, returns at the next posedge+2.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_seq(input int low, input int rec);
    exp_low_q.push_back(low);
    if (rec > 0) exp_rec_q.push_back(rec);
  endtask

  // Monitor: measures each usb_rst_n low pulse and each recovery window.
  initial begin
    int  low_cnt = 0;
    int  rec_cnt = 0;
    logic prev_usb = 1'b0;
    logic prev_busy = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        low_cnt = 0; rec_cnt = 0; prev_usb = 1'b0; prev_busy = 1'b1;
      end else begin
        if (usb_rst_n && !prev_usb) begin
          if (exp_low_q.size() == 0) check_eq("low_q_underflow", 32'd0, 32'd1);
          else check_eq("low_len", low_cnt, exp_low_q.pop_front());
        end
        if (!busy && prev_busy) begin
          if (exp_rec_q.size() == 0) check_eq("rec_q_underflow", 32'd0, 32'd1);
          else check_eq("rec_len", rec_cnt, exp_rec_q.pop_front());
        end
        if (!usb_rst_n) begin
          if (prev_usb) low_cnt = 0;
          low_cnt++;
          rec_cnt = 0;
        end else if (busy) begin
          rec_cnt++;
        end
        prev_usb = usb_rst_n;
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic [31:0] d;
    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check_eq("rst_usb_rst_n", usb_rst_n, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_irq", irq, 1'b0);
    rd(2'd0, d); check_eq("rst_status", d, 32'h5);
    rd(2'd3, d); check_eq("rst_cnt", d, 32'd3);
    rd(2'd2, d); check_eq("rst_irq_en", d, 32'd0);

    // Power-on sequence without software help.
    @(posedge clk); #2;
    push_seq(4, 8);
    reset_n = 1'b1;
    wait_idle(40);
    rd(2'd1, d); check_eq("por_done", d, 32'd1);
    check_eq("por_irq", irq, 1'b0);

    // Software go with interrupt enabled.
    wr(2'd2, 32'd1);
    rd(2'd2, d); check_eq("irq_en_rd", d, 32'd1);
    check_eq("irq_old_done", irq, 1'b1);
    wr(2'd1, 32'd1);
    check_eq("irq_after_clr0", irq, 1'b0);
    push_seq(4, 8);
    wr(2'd0, 32'd1);
    wait_idle(40);
    check_eq("go_irq", irq, 1'b1);
    rd(2'd0, d); check_eq("go_status", d, 32'h2);
    wr(2'd1, 32'd1);
    check_eq("go_irq_clr", irq, 1'b0);

    // Ignored writes.
    wr(2'd0, 32'd0);
    check_eq("addr0_zero_busy", busy, 1'b0);
    wr(2'd3, 32'h0000_1234);
    rd(2'd3, d); check_eq("addr3_ignored", d, 32'd0);

    // Held PIO request stretches the pulse.
    push_seq(10, 8);
    rst_req = 1'b1;
    repeat (10) begin @(posedge clk); #2; end
    rst_req = 1'b0;
    wait_idle(40);
    rd(2'd1, d); check_eq("held_done", d, 32'd1);

    // Restart from RECOVER when cnt is 3.
    wr(2'd1, 32'd1);
    push_seq(4, 0);
    push_seq(4, 8);
    wr(2'd0, 32'd1);
    repeat (8) begin @(posedge clk); #2; end
    rst_req = 1'b1;
    @(posedge clk); #2;
    rst_req = 1'b0;
    rd(2'd0, d); check_eq("restart_status", d, 32'h5);
    wait_idle(40);
    rd(2'd1, d); check_eq("restart_done", d, 32'd1);

    // Clear on the completing cycle: set wins.
    wr(2'd1, 32'd1);
    rd(2'd1, d); check_eq("clr_before_sim", d, 32'd0);
    push_seq(4, 8);
    wr(2'd0, 32'd1);
    repeat (11) begin @(posedge clk); #2; end
    wr(2'd1, 32'd1);
    check_eq("sim_busy", busy, 1'b0);
    rd(2'd1, d); check_eq("sim_done", d, 32'd1);

    // Reset mid-RECOVER aborts and reruns the power-on sequence.
    push_seq(4, 0);
    wr(2'd0, 32'd1);
    repeat (5) begin @(posedge clk); #2; end
    reset_n = 1'b0;
    #1 check_eq("midrst_usb_rst_n", usb_rst_n, 1'b0);
    rd(2'd1, d); check_eq("midrst_done", d, 32'd0);
    rd(2'd0, d); check_eq("midrst_status", d, 32'h5);
    @(posedge clk); @(posedge clk); #2;
    push_seq(4, 8);
    reset_n = 1'b1;
    wait_idle(40);
    rd(2'd1, d); check_eq("midrst_done_after", d, 32'd1);
    check_eq("midrst_irq", irq, 1'b0);

    repeat (2) @(posedge clk);
    check_eq("low_q_left", exp_low_q.size(), 32'd0);
    check_eq("rec_q_left", exp_rec_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
